// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: walks one 256x32 output stripe, issuing one 3x3 window
// read per cycle into the padded stripe buffer, then raises the result write
// strobe and result index a fixed pipeline latency later.
module window_scan_ctrl #(
  parameter int IMG_W       = 256,
  parameter int PAD_W       = 258,
  parameter int STRIPE_ROWS = 32,
  parameter int PIPE_LAT    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  output logic        rd,
  output logic [13:0] rd_base,
  output logic        wr,
  output logic [12:0] wr_addr,
  output logic [7:0]  col,
  output logic [4:0]  row,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0]  COL_LAST = 8'(IMG_W - 1);
  localparam logic [4:0]  ROW_LAST = 5'(STRIPE_ROWS - 1);
  localparam logic [13:0] ROW_STEP = 14'(PAD_W - IMG_W + 1);
  localparam logic [12:0] WR_LAST  = 13'(IMG_W * STRIPE_ROWS - 1);

  state_t              state_r;
  state_t              state_s;
  logic                rd_s;
  logic                done_s;
  logic                last_rd_s;
  logic                launch_s;
  logic [PIPE_LAT:0]   pipe_r;

  // The final window of the stripe sits at the last row and last column.
  assign last_rd_s = (col == COL_LAST) && (row == ROW_LAST);
  assign launch_s  = (state_r == IDLE) && start;
  assign rd        = rd_s;
  assign wr        = pipe_r[PIPE_LAT];

  // Next-state and read-issue decode; the read strobe is the only
  // combinational output, everything else comes from flops.
  always_comb begin
    state_s = state_r;
    rd_s    = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        rd_s = !stall;
        if (!stall && last_rd_s) begin
          state_s = DRAIN;
        end else begin
          state_s = READ;
        end
      end
      DRAIN: begin
        // Only the tail flop may still hold a write: it retires this cycle.
        if (pipe_r[PIPE_LAT-1:0] == {PIPE_LAT{1'b0}}) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with registered busy/done status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      done    <= done_s;
    end
  end

  // Column/row walk and incremental window base; the pitch difference is
  // added on row wrap so no multiplier is needed. The final read holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= 8'd0;
      row     <= 5'd0;
      rd_base <= 14'd0;
    end else if (launch_s) begin
      col     <= 8'd0;
      row     <= 5'd0;
      rd_base <= 14'd0;
    end else if (rd_s && !last_rd_s) begin
      if (col == COL_LAST) begin
        col     <= 8'd0;
        row     <= row + 5'd1;
        rd_base <= rd_base + ROW_STEP;
      end else begin
        col     <= col + 8'd1;
        rd_base <= rd_base + 14'd1;
      end
    end else begin
      col     <= col;
      row     <= row;
      rd_base <= rd_base;
    end
  end

  // Valid pipe: registered memory output stage plus the convolution latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_r <= {(PIPE_LAT+1){1'b0}};
    end else begin
      pipe_r <= {pipe_r[PIPE_LAT-1:0], rd_s};
    end
  end

  // Result index advances after each write and parks on the last entry
  // until the next stripe launch clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= 13'd0;
    end else if (launch_s) begin
      wr_addr <= 13'd0;
    end else if (pipe_r[PIPE_LAT] && (wr_addr != WR_LAST)) begin
      wr_addr <= wr_addr + 13'd1;
    end else begin
      wr_addr <= wr_addr;
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl with a write scoreboard.
module tb_window_scan_ctrl;

  localparam int PIPE_LAT = 3;
  localparam int NREADS   = 256 * 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        rd;
  logic [13:0] rd_base;
  logic        wr;
  logic [12:0] wr_addr;
  logic [7:0]  col;
  logic [4:0]  row;
  logic        busy;
  logic        done;

  window_scan_ctrl #(.IMG_W(256), .PAD_W(258), .STRIPE_ROWS(32), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .rd(rd),
    .rd_base(rd_base), .wr(wr), .wr_addr(wr_addr), .col(col), .row(row),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int addr;
  } wr_exp_t;

  wr_exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc;
  bit m_active;
  int m_col, m_row, m_reads;
  int exp_done_cyc, obs_done_cyc, n_wr, last_base;
  int stall_from = 0, stall_len = 0;
  bit drain_stall = 1'b0, start_hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive stimulus, then compare against the model.
  task automatic step();
    bit exp_rd, exp_busy, exp_wr;
    @(posedge clk); #1;
    cyc++;
    if (!start_hold) start = 1'b0;
    stall = ((stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len) ||
             (drain_stall && !m_active && q.size() > 0)) ? 1'b1 : 1'b0;
    #1;
    exp_busy = m_active || (q.size() > 0);
    exp_rd   = m_active && !stall;
    check("rd", rd, exp_rd);
    check("busy", busy, exp_busy);
    if (exp_rd) begin
      check("rd_base", rd_base, m_row * 258 + m_col);
      check("col", col, m_col);
      check("row", row, m_row);
      if (rd === 1'b1) last_base = rd_base;
      q.push_back('{due: cyc + PIPE_LAT + 1, addr: m_reads});
      m_reads++;
      if (m_col == 255) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
      if (m_reads == NREADS) m_active = 1'b0;
    end
    exp_wr = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_wr = 1'b1;
      check("wr_addr", wr_addr, q[0].addr);
      if (q[0].addr == NREADS - 1) exp_done_cyc = cyc + 1;
      void'(q.pop_front());
    end
    check("wr", wr, exp_wr);
    check("done", done, (cyc == exp_done_cyc) ? 1 : 0);
    if (wr === 1'b1) n_wr++;
    if (done === 1'b1) obs_done_cyc = cyc;
  endtask

  // Runs a scan whose start was sampled at the end of the current cycle.
  task automatic run_scan(input int stop_at);
    int limit;
    cyc = 0; m_active = 1'b1; m_col = 0; m_row = 0; m_reads = 0;
    q.delete(); exp_done_cyc = -1; obs_done_cyc = -1; n_wr = 0; last_base = -1;
    limit = NREADS + PIPE_LAT + 2 + stall_len + 20;
    while (obs_done_cyc < 0 && cyc < limit && !(stop_at > 0 && cyc >= stop_at)) step();
    if (stop_at == 0) begin
      check("done_cycle", obs_done_cyc, NREADS + PIPE_LAT + 2 + stall_len);
      check("wr_count", n_wr, NREADS);
      check("last_rd_base", last_base, 8253);
      check("wr_addr_end", wr_addr, 8191);
    end
  endtask

  task automatic idle_steps(input int n);
    m_active = 1'b0; q.delete(); exp_done_cyc = -1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    cyc = 0; exp_done_cyc = -1;
    #1;
    check("rst_rd", rd, 0);       check("rst_rd_base", rd_base, 0);
    check("rst_wr", wr, 0);       check("rst_wr_addr", wr_addr, 0);
    check("rst_col", col, 0);     check("rst_row", row, 0);
    check("rst_busy", busy, 0);   check("rst_done", done, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle_steps(3);

    // Unstalled scan (also covers row wrap 254,255,258 and final base 8253).
    start = 1'b1;
    run_scan(0);
    idle_steps(3);

    // Ten-cycle stall in mid-row.
    stall_from = 1000; stall_len = 10;
    start = 1'b1;
    run_scan(0);
    stall_from = 0; stall_len = 0;
    idle_steps(3);

    // Start held through the scan, then a back-to-back second scan.
    start_hold = 1'b1;
    start = 1'b1;
    run_scan(0);
    start_hold = 1'b0;
    run_scan(0);
    idle_steps(3);

    // Asynchronous reset mid-scan.
    start = 1'b1;
    run_scan(3000);
    rst_n = 1'b0;
    #1;
    check("arst_rd", rd, 0);       check("arst_rd_base", rd_base, 0);
    check("arst_wr", wr, 0);       check("arst_wr_addr", wr_addr, 0);
    check("arst_col", col, 0);     check("arst_row", row, 0);
    check("arst_busy", busy, 0);   check("arst_done", done, 0);
    idle_steps(2);
    rst_n = 1'b1;
    idle_steps(20);
    start = 1'b1;
    run_scan(0);
    idle_steps(3);

    // Stall asserted only while draining.
    drain_stall = 1'b1;
    start = 1'b1;
    run_scan(0);
    drain_stall = 1'b0;
    idle_steps(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_scan_ctrl.md
# window_scan_ctrl

Sequencer for the 3x3 window stripe memory and its downstream convolution pipe. On `start`, it walks a 256-column by 32-row output stripe and issues one window read per cycle. It drives the window base address into the padded 258-wide stripe buffer, then generates the write strobe and result address after a fixed pipeline latency. It sits between the frame-level control FSM and the stripe memory.

## Interface
- `IMG_W`, 256, output columns per row (window positions per row)
- `PAD_W`, 258, padded row pitch of the stripe buffer, in pixels
- `STRIPE_ROWS`, 32, output rows per stripe
- `PIPE_LAT`, 3, cycles from registered memory window output to valid `pixelw` at memory write port
- `clk` in 1 — single clock, all logic on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — begin one stripe scan; sampled only in IDLE
- `stall` in 1 — downstream back-pressure; suppresses read issue in READ
- `rd` out 1 — window read strobe to memory
- `rd_base` out 14 — window top-left address = row*PAD_W + col
- `wr` out 1 — result write strobe to memory
- `wr_addr` out 13 — result index, 0..IMG_W*STRIPE_ROWS-1
- `col` out 8 — current output column
- `row` out 5 — current output row
- `busy` out 1 — high in READ and DRAIN
- `done` out 1 — one-cycle pulse at stripe completion

## Operation
- States: IDLE, READ, DRAIN. Reset state is IDLE.
- Reset values: `rd_base`=0, `col`=0, `row`=0, `wr_addr`=0, `busy`=0, `done`=0, `rd`=0, `wr`=0, valid pipe cleared.
- IDLE:
  - `start`=1 → READ. Counters and `wr_addr` are cleared on that edge.
  - `start` is ignored in READ and DRAIN.
- READ:
  - `rd` = (state==READ) && !`stall`. This is combinational; it is the only combinational output.
  - Each cycle with `rd`=1: `col` increments. At `col`==IMG_W-1, `col` wraps to 0 and `row` increments.
  - `rd_base` is registered and tracks row*PAD_W+col incrementally: +1 per column, +(PAD_W-IMG_W+1)=+3 on row wrap. No multiplier.
  - Issuing the read at `row`==STRIPE_ROWS-1, `col`==IMG_W-1 (`rd_base`=8253) → DRAIN.
  - `stall`=1: `rd`=0, counters hold, and the valid pipe still shifts a 0 (bubble).
- Valid pipe:
  - Shift register of PIPE_LAT+1 flops fed by `rd`.
  - `wr` = pipe tail.
  - `wr_addr` increments after each `wr`, wrapping to 0 only via a new start.
- DRAIN:
  - `rd`=0; `stall` is ignored.
  - When the pipe is empty after the final `wr` → IDLE, with `done`=1 for exactly one cycle.
- `busy` = state != IDLE.
- Async reset mid-scan aborts immediately. All state returns to reset values, pending writes are dropped, and no `done` is produced.

## Timing
- `start` sampled at edge 0 → READ from edge 1. The first `rd` (base 0) is in the cycle after edge 1, provided `stall`=0.
- Read-to-write latency: a `rd` in cycle n gives `wr` in cycle n+PIPE_LAT+1. The +1 is the memory's registered window output.
- Unstalled stripe, PIPE_LAT=3:
  - `rd` in cycles 1..8192
  - `wr` in cycles 5..8196
  - `done` in cycle 8197
  - back in IDLE from edge 8197, so a new `start` can be accepted on edge 8197
- Each stall cycle in READ delays all later `rd`/`wr`/`done` by one cycle. The number of `wr` pulses is always exactly 8192.
- Widths:
  - max `rd_base` = 31*258+255 = 8253 < 2^14
  - max `wr_addr` = 8191 < 2^13
  - no overflow is possible

## Test plan
- Reset then unstalled scan (PIPE_LAT=3): `start` at edge 0 → `rd`=1 for 8192 consecutive cycles; `wr` in cycles 5..8196; single `done` pulse in cycle 8197; `busy` low after.
- Row wrap: check `rd_base` sequence 254, 255, 258 around `col` 255→0 on row 0→1; last `rd_base`=8253; `wr_addr` ends at 8191.
- Stall: hold `stall`=1 for 10 cycles in mid-row → `rd`=0, `col`/`rd_base` frozen; `wr` shows a matching 10-cycle gap PIPE_LAT+1 cycles later; `done` at cycle 8207.
- `start` held high throughout the scan → no restart, exactly one `done`. A new `start` in the cycle after `done` begins a second scan at `rd_base`=0.
- Async reset asserted at cycle 3000 → all outputs at reset values immediately (no clock edge needed); no further `wr` or `done`; a fresh `start` gives a full, correct 8192-write scan.
- `stall` asserted only during DRAIN → no effect; `wr` and `done` timing are identical to the unstalled run.
